// File: rtl/store_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Purpose  : Posted-write queue between the MEM-stage store path and the
//             data memory (Dm). Stores are accepted in one cycle and drained
//             to Dm one per cycle, only while no load owns the Dm port. A load
//             whose word matches any pending store is stalled until that
//             store has drained, so Dm read data is always current.
//  Ports    : clk, reset           - clock, synchronous active-high reset
//             st_valid/addr/data/ctrl/pc - MEM-stage store request
//             ld_valid/ld_addr     - MEM-stage load request
//             stall                - hold MEM stage and upstream
//             full, empty          - queue occupancy flags
//             dm_wEn/addr/dIn/saveCtrl/pc - Dm write/address port
//  Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [4:0]  st_ctrl,
    input  logic [31:0] st_pc,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        stall,
    output logic        full,
    output logic        empty,
    output logic        dm_wEn,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_dIn,
    output logic [4:0]  dm_saveCtrl,
    output logic [31:0] dm_pc
);

    localparam logic [PTR_W:0] c_FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [4:0]       r_ctrl [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic w_ctrlOk;
    logic w_full;
    logic w_empty;
    logic w_anyMatch;
    logic w_hit;
    logic w_drain;
    logic w_enq;

    assign w_ctrlOk = (st_ctrl == 5'd1) || (st_ctrl == 5'd2) || (st_ctrl == 5'd3);
    assign w_full   = (r_count == c_FULL_COUNT);
    assign w_empty  = (r_count == '0);

    // Word-granular match against every occupied slot. A slot is occupied when
    // its distance from head (modulo DEPTH) is below the current count.
    always_comb begin
        logic [PTR_W-1:0] off;
        off        = '0;
        w_anyMatch = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - r_head;
            if (({1'b0, off} < r_count) && (r_addr[i][13:2] == ld_addr[13:2]))
                w_anyMatch = 1'b1;
        end
    end

    // Reset suppresses the Dm write and the stall in the same cycle so that
    // pending stores are dropped rather than partially written.
    assign w_hit   = !reset && ld_valid && w_anyMatch;
    assign w_drain = !reset && !w_empty && (!ld_valid || w_hit);
    // Full is the registered count: a simultaneous drain does not make room.
    assign w_enq   = st_valid && w_ctrlOk && !w_full;

    assign stall = !reset && ((st_valid && w_ctrlOk && w_full) || w_hit);
    assign full  = w_full;
    assign empty = w_empty;

    always_comb begin
        dm_wEn      = 1'b0;
        dm_addr     = ld_addr;
        dm_dIn      = 32'd0;
        dm_saveCtrl = 5'd0;
        dm_pc       = 32'd0;
        if (w_drain) begin
            dm_wEn      = 1'b1;
            dm_addr     = r_addr[r_head];
            dm_dIn      = r_data[r_head];
            dm_saveCtrl = r_ctrl[r_head];
            dm_pc       = r_pc[r_head];
        end
    end

    // Entry storage needs no reset: occupancy is defined by head/count only.
    always_ff @(posedge clk) begin
        if (!reset && w_enq) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
            r_ctrl[r_tail] <= st_ctrl;
            r_pc[r_tail]   <= st_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_tail <= r_tail + 1'b1;
            if (w_drain)
                r_head <= r_head + 1'b1;
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
